// File: rtl/case_1_accum_pkg.sv
// Shared types and constants for the case_1 product accumulator.
// Saturation bounds are derived from the accumulator width.
package case_1_accum_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int PROD_W = 19;
   localparam int ACC_W  = 32;
   localparam int CNT_W  = 16;

   function automatic logic signed [63:0] acc_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] acc_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/case_1_sat_add.sv
// Signed accumulate step with clamping to the accumulator range.
// One guard bit holds the true sum before the range check.
module case_1_sat_add
   import case_1_accum_pkg::*;
#(
   parameter int PROD_WIDTH = PROD_W,
   parameter int ACC_WIDTH  = ACC_W
) (
   input  logic signed [ACC_WIDTH-1:0]  acc,
   input  logic signed [PROD_WIDTH-1:0] prod,
   output logic signed [ACC_WIDTH-1:0]  sum,
   output logic                         ovf
);

   localparam logic signed [ACC_WIDTH:0] MAX =
      (ACC_WIDTH+1)'(acc_max(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH:0] MIN =
      (ACC_WIDTH+1)'(acc_min(ACC_WIDTH));

   logic signed [ACC_WIDTH:0] wide;

   always_comb begin
      wide = {acc[ACC_WIDTH-1], acc}
           + {{(ACC_WIDTH+1-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
      sum  = wide[ACC_WIDTH-1:0];
      ovf  = 1'b0;
      if (wide > MAX) begin
         sum = MAX[ACC_WIDTH-1:0];
         ovf = 1'b1;
      end else if (wide < MIN) begin
         sum = MIN[ACC_WIDTH-1:0];
         ovf = 1'b1;
      end
   end

endmodule

// File: rtl/case_1_prod_accum.sv
// Group accumulator for case_1 products: saturating sum, beat count
// and sticky overflow, presented on a held output handshake.
module case_1_prod_accum
   import case_1_accum_pkg::*;
#(
   parameter int PROD_WIDTH = PROD_W,
   parameter int ACC_WIDTH  = ACC_W,
   parameter int CNT_WIDTH  = CNT_W
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic signed [PROD_WIDTH-1:0] in_prod,
   input  logic                         in_last,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic signed [ACC_WIDTH-1:0]  out_sum,
   output logic [CNT_WIDTH-1:0]         out_cnt,
   output logic                         out_sat,
   output logic                         out_valid,
   input  logic                         out_ready
);

   state_t                       state;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic [CNT_WIDTH-1:0]         cnt;
   logic                         sat;

   logic signed [ACC_WIDTH-1:0]  add_sum;
   logic                         add_ovf;
   logic [CNT_WIDTH-1:0]         cnt_nxt;
   logic                         sat_nxt;

   case_1_sat_add #(
      .PROD_WIDTH (PROD_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_add (
      .acc  (acc),
      .prod (in_prod),
      .sum  (add_sum),
      .ovf  (add_ovf)
   );

   // Reset is folded in so the source sees no ready while held in reset.
   assign in_ready = ap_rst_n && (state != HOLD);
   assign cnt_nxt  = (&cnt) ? cnt : cnt + 1'b1;
   assign sat_nxt  = sat | add_ovf;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         sat       <= 1'b0;
         out_sum   <= '0;
         out_cnt   <= '0;
         out_sat   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE, ACC: begin
               if (in_valid) begin
                  acc <= add_sum;
                  cnt <= cnt_nxt;
                  sat <= sat_nxt;
                  if (in_last) begin
                     state     <= HOLD;
                     out_sum   <= add_sum;
                     out_cnt   <= cnt_nxt;
                     out_sat   <= sat_nxt;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  acc       <= '0;
                  cnt       <= '0;
                  sat       <= 1'b0;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
